// File: rtl/count_driver_if.sv
// Command and counter-control bundle between count_driver and its command source / counter.
interface count_driver_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned OVF_CNT_W = 8
);
   logic                 cmd_valid_in;
   logic                 cmd_ready_out;
   logic [1:0]           cmd_op_in;
   logic [WIDTH-1:0]     cmd_value_in;
   logic [WIDTH-1:0]     cmd_len_in;
   logic                 en_ctl_out;
   logic                 set_ctrl_out;
   logic                 up_ctrl_out;
   logic [WIDTH-1:0]     counter_val_out;
   logic [WIDTH-1:0]     counter_fb_in;
   logic                 ovf_fb_in;
   logic                 busy_out;
   logic                 done_out;
   logic                 err_out;
   logic [OVF_CNT_W-1:0] ovf_cnt_out;
   logic [WIDTH-1:0]     exp_out;

   // Driver side: consumes commands and counter feedback, drives controls and status.
   modport slave (
      input  cmd_valid_in, cmd_op_in, cmd_value_in, cmd_len_in,
      input  counter_fb_in, ovf_fb_in,
      output cmd_ready_out, en_ctl_out, set_ctrl_out, up_ctrl_out, counter_val_out,
      output busy_out, done_out, err_out, ovf_cnt_out, exp_out
   );

   // Command source / counter side.
   modport master (
      output cmd_valid_in, cmd_op_in, cmd_value_in, cmd_len_in,
      output counter_fb_in, ovf_fb_in,
      input  cmd_ready_out, en_ctl_out, set_ctrl_out, up_ctrl_out, counter_val_out,
      input  busy_out, done_out, err_out, ovf_cnt_out, exp_out
   );
endinterface

// File: rtl/count_driver.sv
// Turns LOAD/UP/DOWN/HOLD commands into counter controls, shadows the expected
// count and flags any divergence of the counter feedback from that shadow.
module count_driver #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned OVF_CNT_W = 8
) (
   input logic          clk_in,
   input logic          nrst_in,
   count_driver_if.slave bus
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;

   localparam logic [WIDTH-1:0]     VAL_MAX = '1;
   localparam logic [OVF_CNT_W-1:0] OVF_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       op, op_nxt;
   logic [WIDTH-1:0] value, value_nxt;
   logic [WIDTH-1:0] step, step_nxt;
   logic             zero_len, zero_len_nxt;

   logic             en_nxt, set_nxt, up_nxt;
   logic [WIDTH-1:0] cval_nxt;
   logic             ready_nxt, busy_nxt, done_nxt, cmp_nxt;

   logic             en_q, set_q, up_q, ready_q, busy_q, done_q, cmp_valid;
   logic [WIDTH-1:0] cval_q;

   logic [WIDTH-1:0]     exp_q;
   logic                 exp_ovf;
   logic                 err_q;
   logic [OVF_CNT_W-1:0] ovf_cnt_q;

   // State register plus latched command and registered control/status outputs.
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state     <= IDLE;
         op        <= OP_LOAD;
         value     <= '0;
         step      <= '0;
         zero_len  <= 1'b0;
         en_q      <= 1'b0;
         set_q     <= 1'b0;
         up_q      <= 1'b0;
         cval_q    <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cmp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         op        <= op_nxt;
         value     <= value_nxt;
         step      <= step_nxt;
         zero_len  <= zero_len_nxt;
         en_q      <= en_nxt;
         set_q     <= set_nxt;
         up_q      <= up_nxt;
         cval_q    <= cval_nxt;
         ready_q   <= ready_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
         cmp_valid <= cmp_nxt;
      end
   end

   // Next-state: accept in IDLE, count steps in DRIVE, one compare cycle in CHECK.
   always_comb begin
      state_nxt    = state;
      op_nxt       = op;
      value_nxt    = value;
      step_nxt     = step;
      zero_len_nxt = zero_len;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid_in) begin
               op_nxt    = bus.cmd_op_in;
               value_nxt = bus.cmd_value_in;
               if (bus.cmd_op_in == OP_LOAD) begin
                  step_nxt     = WIDTH'(1);
                  zero_len_nxt = 1'b0;
                  state_nxt    = DRIVE;
               end else if (bus.cmd_len_in == '0) begin
                  step_nxt     = '0;
                  zero_len_nxt = 1'b1;
                  state_nxt    = CHECK;
               end else begin
                  step_nxt     = bus.cmd_len_in;
                  zero_len_nxt = 1'b0;
                  state_nxt    = DRIVE;
               end
            end
         end
         DRIVE: begin
            step_nxt = step - WIDTH'(1);
            if (step == WIDTH'(1)) begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so controls are valid the cycle after the edge.
   always_comb begin
      en_nxt    = 1'b0;
      set_nxt   = 1'b0;
      up_nxt    = 1'b0;
      cval_nxt  = '0;
      ready_nxt = (state_nxt == IDLE);
      busy_nxt  = (state_nxt != IDLE);
      done_nxt  = (state == CHECK);
      cmp_nxt   = (state == DRIVE) || ((state == CHECK) && zero_len);
      if (state_nxt == DRIVE) begin
         if (op_nxt == OP_LOAD) begin
            set_nxt  = 1'b1;
            cval_nxt = value_nxt;
         end else if ((op_nxt == OP_UP) || (op_nxt == OP_DOWN)) begin
            en_nxt = 1'b1;
            up_nxt = (op_nxt == OP_UP);
         end
      end
   end

   // Shadow counter: same update rule as the counter, from the controls it sees.
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         exp_q   <= '0;
         exp_ovf <= 1'b0;
      end else if (set_q) begin
         exp_q   <= cval_q;
         exp_ovf <= 1'b0;
      end else if (en_q) begin
         if (up_q) begin
            exp_q   <= exp_q + WIDTH'(1);
            exp_ovf <= (exp_q == VAL_MAX);
         end else begin
            exp_q   <= exp_q - WIDTH'(1);
            exp_ovf <= (exp_q == '0);
         end
      end else begin
         exp_ovf <= 1'b0;
      end
   end

   // Sticky mismatch flag, evaluated one cycle after each driven step.
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         err_q <= 1'b0;
      end else if (cmp_valid && ((bus.counter_fb_in != exp_q) || (bus.ovf_fb_in != exp_ovf))) begin
         err_q <= 1'b1;
      end
   end

   // Saturating count of cycles with counter overflow feedback.
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         ovf_cnt_q <= '0;
      end else if (bus.ovf_fb_in && (ovf_cnt_q != OVF_MAX)) begin
         ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
      end
   end

   assign bus.cmd_ready_out   = ready_q;
   assign bus.en_ctl_out      = en_q;
   assign bus.set_ctrl_out    = set_q;
   assign bus.up_ctrl_out     = up_q;
   assign bus.counter_val_out = cval_q;
   assign bus.busy_out        = busy_q;
   assign bus.done_out        = done_q;
   assign bus.err_out         = err_q;
   assign bus.ovf_cnt_out     = ovf_cnt_q;
   assign bus.exp_out         = exp_q;

endmodule

// File: tb/tb_count_driver.sv
// Bench for count_driver: emulates the counter, issues directed and random commands,
// and checks against a transaction-level model of count, overflow total and timing.
module tb_count_driver;

   logic clk;
   logic nrst;

   count_driver_if #(.WIDTH(8), .OVF_CNT_W(8)) bus ();

   count_driver #(.WIDTH(8), .OVF_CNT_W(8)) dut (
      .clk_in  (clk),
      .nrst_in (nrst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter emulation: set beats enable, ovf pulses for one cycle after a wrap.
   logic [7:0] cnt_q;
   logic       cnt_ovf;
   logic       force_fb;
   logic [7:0] force_val;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q   <= 8'h00;
         cnt_ovf <= 1'b0;
      end else if (bus.set_ctrl_out) begin
         cnt_q   <= bus.counter_val_out;
         cnt_ovf <= 1'b0;
      end else if (bus.en_ctl_out) begin
         cnt_q   <= bus.up_ctrl_out ? cnt_q + 8'd1 : cnt_q - 8'd1;
         cnt_ovf <= bus.up_ctrl_out ? (cnt_q == 8'hFF) : (cnt_q == 8'h00);
      end else begin
         cnt_ovf <= 1'b0;
      end
   end

   assign bus.counter_fb_in = force_fb ? force_val : cnt_q;
   assign bus.ovf_fb_in     = cnt_ovf;

   int checks   = 0;
   int failures = 0;

   // Transaction-level model state.
   int m_exp = 0;
   int m_ovf = 0;
   bit m_err = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, act, req, $time);
      end
   endtask

   // Expected shadow count j edges after the handshake.
   function automatic int traj(input int op, input int start, input int v, input int len, input int j);
      int m;
      m = (j < len) ? j : len;
      case (op)
         0:       return (j >= 1) ? v : start;
         1:       return (start + m) % 256;
         2:       return (start - m + 256) % 256;
         default: return start;
      endcase
   endfunction

   task automatic check_reset(input string tag);
      check_eq({tag, "_ready"}, bus.cmd_ready_out, 1);
      check_eq({tag, "_busy"}, bus.busy_out, 0);
      check_eq({tag, "_done"}, bus.done_out, 0);
      check_eq({tag, "_err"}, bus.err_out, 0);
      check_eq({tag, "_ovfcnt"}, bus.ovf_cnt_out, 0);
      check_eq({tag, "_exp"}, bus.exp_out, 0);
      check_eq({tag, "_en"}, bus.en_ctl_out, 0);
      check_eq({tag, "_set"}, bus.set_ctrl_out, 0);
      check_eq({tag, "_up"}, bus.up_ctrl_out, 0);
      check_eq({tag, "_val"}, bus.counter_val_out, 0);
   endtask

   // Issue one command and follow it to done; called #1 after a rising edge.
   task automatic run_cmd(input int op, input int v, input int len, input bit inject);
      int  steps, start, j, en_n, set_n, wait_n, final_v, wraps;
      bit  seen;
      start = m_exp;
      steps = (op == 0) ? 1 : len;
      wait_n = 0;
      while (!bus.cmd_ready_out && wait_n < 400) begin
         @(posedge clk); #1;
         wait_n++;
      end
      check_eq("ready_before_cmd", bus.cmd_ready_out, 1);
      bus.cmd_valid_in = 1'b1;
      bus.cmd_op_in    = 2'(op);
      bus.cmd_value_in = 8'(v);
      bus.cmd_len_in   = 8'(len);
      @(posedge clk); #1;
      bus.cmd_valid_in = 1'b0;
      bus.cmd_op_in    = 2'($urandom);
      bus.cmd_value_in = 8'($urandom);
      bus.cmd_len_in   = 8'($urandom);
      if (inject) begin
         force_val = 8'(m_exp - 1);
         force_fb  = 1'b1;
      end
      j = 0; seen = 1'b0; en_n = 0; set_n = 0;
      while (!seen && j <= 300) begin
         if (inject && j >= 2) m_err = 1'b1;
         check_eq("exp_step", bus.exp_out, traj(op, start, v, len, j));
         check_eq("busy_step", bus.busy_out, (j <= steps) ? 1 : 0);
         check_eq("err_step", bus.err_out, m_err);
         if (bus.en_ctl_out) begin
            en_n++;
            check_eq("up_dir", bus.up_ctrl_out, (op == 1) ? 1 : 0);
         end
         if (bus.set_ctrl_out) begin
            set_n++;
            check_eq("set_val", bus.counter_val_out, v);
         end
         if (bus.done_out) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            j++;
         end
      end
      force_fb = 1'b0;
      check_eq("done_seen", seen, 1);
      check_eq("latency", j + 1, steps + 2);
      check_eq("en_cycles", en_n, (op == 1 || op == 2) ? len : 0);
      check_eq("set_cycles", set_n, (op == 0) ? 1 : 0);
      final_v = traj(op, start, v, len, 1000);
      wraps = 0;
      if (op == 1 && start + len > 255) wraps = 1;
      if (op == 2 && len > start) wraps = 1;
      m_exp = final_v;
      m_ovf = (m_ovf + wraps > 255) ? 255 : m_ovf + wraps;
      check_eq("exp_final", bus.exp_out, m_exp);
      check_eq("ovf_cnt", bus.ovf_cnt_out, m_ovf);
      check_eq("err_final", bus.err_out, m_err);
   endtask

   initial begin
      int rop, rlen, wait_n;
      bit seen_done;
      nrst             = 1'b0;
      bus.cmd_valid_in = 1'b0;
      bus.cmd_op_in    = 2'b00;
      bus.cmd_value_in = 8'h00;
      bus.cmd_len_in   = 8'h00;
      force_fb         = 1'b0;
      force_val        = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk); #1;

      run_cmd(0, 8'hA5, 0, 1'b0);
      run_cmd(0, 8'hFD, 0, 1'b0);
      run_cmd(1, 0, 5, 1'b0);
      run_cmd(0, 8'h01, 0, 1'b0);
      run_cmd(2, 0, 3, 1'b0);
      run_cmd(1, 0, 0, 1'b0);
      run_cmd(3, 0, 0, 1'b0);
      run_cmd(0, 8'h80, 0, 1'b0);
      run_cmd(1, 0, 255, 1'b0);
      run_cmd(2, 0, 255, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rop  = int'($urandom_range(0, 3));
         rlen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
         run_cmd(rop, int'($urandom_range(0, 255)), rlen, 1'b0);
      end

      run_cmd(0, 8'h11, 0, 1'b0);
      run_cmd(3, 0, 4, 1'b1);
      run_cmd(0, 8'h22, 0, 1'b0);
      run_cmd(1, 0, 3, 1'b0);

      // Long UP interrupted by reset.
      wait_n = 0;
      while (!bus.cmd_ready_out && wait_n < 10) begin
         @(posedge clk); #1;
         wait_n++;
      end
      bus.cmd_valid_in = 1'b1;
      bus.cmd_op_in    = 2'b01;
      bus.cmd_len_in   = 8'd200;
      @(posedge clk); #1;
      bus.cmd_valid_in = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check_eq("mid_en", bus.en_ctl_out, 1);
      check_eq("mid_exp", bus.exp_out, (m_exp + 50) % 256);
      nrst = 1'b0;
      #1;
      check_reset("mid_rst");
      m_exp = 0; m_ovf = 0; m_err = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      seen_done = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.done_out) seen_done = 1'b1;
      end
      check_eq("no_done_after_rst", seen_done, 0);
      check_eq("ready_after_rst", bus.cmd_ready_out, 1);
      run_cmd(0, 8'h5A, 0, 1'b0);
      run_cmd(2, 0, 6, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d want=0", $time);
      $fatal(1, "time limit");
   end

endmodule
